// File: rtl/mem_access_unit.sv
// Load/store unit: one outstanding bus access per accepted EX request, with
// lane steering for stores, extraction and extension for loads, and a misalignment trap.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_we_i,
  input  logic [4:0]            rd_addr_i,
  output logic                  stall_o,
  output logic                  reg_we_o,
  output logic [4:0]            reg_waddr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic                  misalign_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [3:0]            bus_be_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_RESP = 2'd2, S_DONE = 2'd3;

  localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                         OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  logic [1:0]            state;
  logic [3:0]            op_q;
  logic [1:0]            off_q;
  logic                  we_q;
  logic [4:0]            rd_q;

  logic                  accept, misaligned, is_byte, is_half;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d, rd_shift, ld_data;

  always_comb begin
    is_byte    = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
    is_half    = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
    misaligned = (is_half && mem_addr_i[0]) ||
                 (((mem_op_i == OP_LW) || (mem_op_i == OP_SW)) && (mem_addr_i[1:0] != 2'b00));
    accept     = (state == S_IDLE) && req_valid_i && (mem_op_i != OP_NOP);

    if (is_byte)      be_d = 4'b0001 << mem_addr_i[1:0];
    else if (is_half) be_d = 4'b0011 << mem_addr_i[1:0];
    else              be_d = 4'b1111;

    // Stores replicate the low byte/half across every lane; the bus picks via be.
    wdata_d = '0;
    if (mem_we_i) begin
      if (is_byte)
        for (int i = 0; i < DATA_WIDTH/8; i++) wdata_d[8*i +: 8] = mem_data_i[7:0];
      else if (is_half)
        for (int i = 0; i < DATA_WIDTH/16; i++) wdata_d[16*i +: 16] = mem_data_i[15:0];
      else
        wdata_d = mem_data_i;
    end
  end

  always_comb begin
    rd_shift = bus_rdata_i >> {off_q, 3'b000};
    case (op_q)
      OP_LB:   ld_data = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      OP_LBU:  ld_data = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
      OP_LH:   ld_data = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      OP_LHU:  ld_data = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
      default: ld_data = bus_rdata_i;
    endcase
  end

  // Combinational so the pipeline freezes in the same cycle the request is taken.
  assign stall_o = !rst_i && ((accept && !misaligned) || (state == S_ADDR) || (state == S_RESP));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      off_q       <= 2'b00;
      we_q        <= 1'b0;
      rd_q        <= 5'd0;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= 5'd0;
      reg_wdata_o <= '0;
      misalign_o  <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= '0;
    end else begin
      misalign_o  <= 1'b0;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= 5'd0;
      reg_wdata_o <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              op_q        <= mem_op_i;
              off_q       <= mem_addr_i[1:0];
              we_q        <= mem_we_i;
              rd_q        <= rd_addr_i;
              bus_req_o   <= 1'b1;
              bus_we_o    <= mem_we_i;
              bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
              bus_be_o    <= be_d;
              bus_wdata_o <= wdata_d;
              state       <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          // Write-back is registered here so it appears exactly while in DONE.
          if (bus_rvalid_i) begin
            state <= S_DONE;
            if (!we_q) begin
              reg_we_o    <= 1'b1;
              reg_waddr_o <= rd_q;
              reg_wdata_o <= ld_data;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data-path width of the load/store and bus data.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the byte-address width.
REQ-003 Clocking SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  SHALL be the synchronous active-high reset.
REQ-006 req_valid_i  in  1  SHALL indicate that the EX-stage request is present this cycle.
REQ-007 mem_op_i  in  4  SHALL carry the memory op: MEM_NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8.
REQ-008 mem_addr_i  in  ADDR_WIDTH  SHALL carry the byte address.
REQ-009 mem_data_i  in  DATA_WIDTH  SHALL carry the store data; the low bytes are used.
REQ-010 mem_we_i  in  1  SHALL be 1 for stores and 0 for loads.
REQ-011 rd_addr_i  in  5  SHALL carry the load destination register.
REQ-012 stall_o  out  1  SHALL request that the pipeline hold its EX outputs.
REQ-013 reg_we_o / reg_waddr_o / reg_wdata_o  out  1/5/DATA_WIDTH  SHALL form the load write-back port.
REQ-014 misalign_o  out  1  SHALL pulse for one cycle on a misaligned request.
REQ-015 bus_req_o, bus_we_o  out  1 each  SHALL be the address-phase request and write flag.
REQ-016 bus_addr_o  out  ADDR_WIDTH  SHALL carry a word-aligned address with bits [1:0]=0.
REQ-017 bus_be_o  out  4  SHALL carry the byte enables.
REQ-018 bus_wdata_o  out  DATA_WIDTH  SHALL carry the lane-shifted store data.
REQ-019 bus_gnt_i, bus_rvalid_i  in  1 each  SHALL be the address-phase accept and response-phase valid.
REQ-020 bus_rdata_i  in  DATA_WIDTH  SHALL carry the full read word.

Function
REQ-021 FSM SHALL have states IDLE, ADDR, RESP and DONE.
REQ-022 In IDLE, a cycle with req_valid_i=1 and mem_op_i!=MEM_NOP SHALL be accepted.
REQ-023 Accepting a request SHALL latch op, address, data and rd, and move the FSM to ADDR; stall_o SHALL be combinationally 1 in that cycle.
REQ-024 A misaligned request (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL NOT start a bus transaction.
REQ-025 A misaligned request SHALL pulse misalign_o for 1 cycle, with no register write and stall_o=0, and the FSM SHALL stay in IDLE.
REQ-026 In ADDR, bus_req_o SHALL be 1 and bus_addr/be/we/wdata SHALL be held stable until the cycle bus_gnt_i=1, after which the FSM SHALL move to RESP.
REQ-027 Byte enables SHALL be: byte ops 4'b0001<<addr[1:0]; halfword ops 4'b0011<<addr[1:0]; word ops 4'b1111.
REQ-028 Store data SHALL be replicated per lane: SB {4{d[7:0]}}; SH {2{d[15:0]}}; SW d.
REQ-029 In RESP, the FSM SHALL wait for bus_rvalid_i=1 and move to DONE in the following cycle; bus_rvalid_i in the same cycle as bus_gnt_i SHALL NOT be accepted.
REQ-030 In DONE, loads SHALL set reg_we_o=1 for exactly 1 cycle, with reg_waddr_o=latched rd.
REQ-031 Load data SHALL be selected by addr[1:0]: LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
REQ-032 In DONE, stores SHALL set reg_we_o=0.
REQ-033 stall_o SHALL be 1 in ADDR and RESP and 0 in DONE.
REQ-034 The FSM SHALL return to IDLE from DONE.
REQ-035 A new request SHALL be accepted only in IDLE; minimum latency from acceptance to write-back SHALL be 3 cycles with zero-wait gnt/rvalid.
REQ-036 req_valid_i while the FSM is not in IDLE SHALL be ignored; the pipeline holds it via stall_o.
REQ-037 Outputs SHALL be registered except stall_o.
REQ-038 Outside DONE, reg_wdata_o SHALL be 0.
REQ-039 Outside ADDR, bus_req_o SHALL be 0.

Reset
REQ-040 rst_i=1 SHALL force the FSM to IDLE.
REQ-041 rst_i=1 SHALL force all outputs to 0: stall, reg_we, reg_waddr, reg_wdata, misalign, bus_req, bus_we, bus_addr, bus_be and bus_wdata.
REQ-042 Reset during ADDR or RESP SHALL abandon the transaction without a write-back; a late bus_rvalid_i after reset SHALL be ignored in IDLE.

Verification
REQ-043 LB at addr 0x103, bus_rdata=0x80FF_1234, gnt/rvalid 0-wait -> reg_wdata_o=0xFFFF_FF80 and reg_we_o=1 exactly 3 cycles after acceptance.
REQ-044 LHU at addr 0x102, rdata=0xBEEF_0000 -> reg_wdata_o=0x0000_BEEF; the same access as LH -> 0xFFFF_BEEF.
REQ-045 SH at addr 0x202, data 0x1234_ABCD, gnt delayed 3 cycles -> bus_addr=0x200, be=4'b1100, wdata=0xABCD_ABCD held stable, stall_o=1 throughout, reg_we_o never 1.
REQ-046 LW at addr 0x101 -> misalign_o pulses 1 cycle, bus_req_o stays 0, stall_o stays 0.
REQ-047 rst_i asserted in RESP, then rvalid arrives -> all outputs 0, no write-back, and the next LW proceeds normally.
REQ-048 req_valid_i held through a busy transaction -> exactly one bus transaction per accepted request.
